multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multicycle control FSM for the RV32I subset CPU. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, and handshakes with instruction and data memories that have variable latency. It drives every datapath enable and mux select, resolves BEQ/BNE from the ALU `EQ` flag, and counts retired instructions. It sits between the instruction register (IR) and the datapath (PC, register file, ALU, data memory).

## Interface
- `ALUCTRL_WIDTH`, default 3: width of `ALUctrl`. Minimum 3.
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: IR contents. The datapath holds it stable from DECODE until the next `IRWrite`.
- `EQ` in 1: ALU equality flag, valid in EXEC.
- `imem_ready` in 1: instruction word is valid this cycle.
- `dmem_ready` in 1: data access completes this cycle.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write enable.
- `IRWrite` out 1: load the IR.
- `PCWrite` out 1: update the PC.
- `PCsrc` out 2: PC source. 0 = PC+4, 1 = PC+immB, 2 = PC+immJ.
- `RegWrite` out 1: register file write enable.
- `ALUctrl` out `ALUCTRL_WIDTH`: ALU operation. 0 = add, 1 = sub. Zero-extended to the port width.
- `ALUsrc` out 1: ALU operand B select. 0 = rs2, 1 = immediate.
- `ImmSrc` out 2: immediate format. 0 = I, 1 = S, 2 = B, 3 = J.
- `ResultSrc` out 2: write-back source. 0 = ALU, 1 = memory, 2 = PC+4.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `instret` out `CNT_WIDTH`: retired-instruction count.
- `illegal` out 1: trap flag.

## Operation
Decoded instructions:
- ADDI: opcode 0010011, funct3 000.
- ADD/SUB: opcode 0110011, funct3 000, funct7 0000000 / 0100000.
- LW: opcode 0000011, funct3 010.
- SW: opcode 0100011, funct3 010.
- BEQ/BNE: opcode 1100011, funct3 000 / 001.
- JAL: opcode 1101111.
- Any other encoding is illegal.

All outputs are 0 unless listed for the current state.

States:
- **FETCH**
  - `imem_req`=1.
  - On `imem_ready`: `IRWrite`=1, go to DECODE. Otherwise stay in FETCH.
- **DECODE**: one cycle, no enables asserted.
  - Legal instruction: go to EXEC.
  - Illegal instruction: see Configuration.
- **EXEC**: sets `ALUctrl`, `ALUsrc` and `ImmSrc` per instruction. ADD is 0, SUB and branches are 1.
  - ADDI, ADD, SUB: go to WB.
  - LW, SW: add with `ALUsrc`=1 and `ImmSrc`=0 (LW) or 1 (SW); go to MEM.
  - Branch:
    - `PCWrite`=1, `retire`=1.
    - `PCsrc`=1 if taken, else 0. BEQ is taken when `EQ`=1; BNE is taken when `EQ`=0.
    - Go to FETCH.
  - JAL: go to WB.
- **MEM**
  - `dmem_req`=1; `dmem_we`=1 for SW.
  - Stay until `dmem_ready`.
  - LW: go to WB.
  - SW: `PCWrite`=1, `PCsrc`=0, `retire`=1 in the ready cycle; go to FETCH.
- **WB**
  - `RegWrite`=1 and `PCWrite`=1.
  - `ResultSrc`: 0 for ALU ops, 1 for LW, 2 for JAL.
  - `PCsrc`: 2 for JAL (with `ImmSrc`=3), otherwise 0.
  - `retire`=1; go to FETCH.

Counter:
- `instret` increments by 1 on every cycle with `retire`=1.
- Wraps from 2^`CNT_WIDTH`−1 to 0 with no flag.

## Timing
- Reset:
  - While `rst_n`=0, the state is FETCH and `instret`=0.
  - All outputs are forced to 0, including `imem_req` and `illegal`.
  - The first `imem_req` is asserted in the first cycle after `rst_n` rises.
- Outputs are combinational from the registered state and `instr`. `EQ`, `imem_ready` and `dmem_ready` may affect outputs in the same cycle.
- Latency with zero-wait memories (ready in the first request cycle):
  - Branch: 3 cycles.
  - ADDI, ADD, SUB, SW, JAL: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1 cycle.
- Request signals stay asserted and stable until their ready arrives. A ready signal outside its matching state is ignored.
- Reset mid-instruction aborts the instruction with no further write or retire.

## Configuration
- `MCU_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction in DECODE moves the FSM to TRAP.
  - TRAP holds `illegal`=1 with all other outputs 0, no retire.
  - The FSM stays in TRAP until reset.
- `MCU_ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction is a NOP: DECODE asserts `PCWrite`=1, `PCsrc`=0, `retire`=1, then goes to FETCH.
  - `illegal` is tied to 0.

## Test plan
- Reset release, IR = ADDI (0x00500093), `imem_ready` held 1: `IRWrite` in cycle 1; EXEC with `ALUsrc`=1, `ALUctrl`=0; WB with `RegWrite`=1, `ResultSrc`=0; `retire` in cycle 4; `instret`=1.
- BNE (funct3 001) with `EQ`=0 gives `PCsrc`=1, `PCWrite`=1 in EXEC. Same instruction with `EQ`=1 gives `PCsrc`=0. BEQ gives the inverse. Each takes 3 cycles.
- LW with `dmem_ready` delayed 3 cycles: `dmem_req` held for 4 MEM cycles, `dmem_we`=0; WB has `ResultSrc`=1; total latency 8.
- SW then JAL: SW MEM cycle has `dmem_we`=1 and `RegWrite` is never asserted. JAL WB has `PCsrc`=2, `ResultSrc`=2, `RegWrite`=1.
- Illegal opcode 0x0000007F:
  - With the macro: TRAP entered, `illegal`=1, `instret` unchanged, exits only on `rst_n`=0.
  - Without the macro: NOP retire in DECODE, `instret`+1.
- `CNT_WIDTH`=4: after 16 retires `instret` wraps to 0. Asserting `rst_n`=0 during MEM clears all outputs immediately.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle RV32I-subset control FSM with variable-latency memory handshakes.
// Define MCU_ILLEGAL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module multicycle_control_unit #(
   parameter int ALUCTRL_WIDTH = 3,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              instr,
   input  logic                     EQ,
   input  logic                     imem_ready,
   input  logic                     dmem_ready,
   output logic                     imem_req,
   output logic                     dmem_req,
   output logic                     dmem_we,
   output logic                     IRWrite,
   output logic                     PCWrite,
   output logic [1:0]               PCsrc,
   output logic                     RegWrite,
   output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
   output logic                     ALUsrc,
   output logic [1:0]               ImmSrc,
   output logic [1:0]               ResultSrc,
   output logic                     retire,
   output logic [CNT_WIDTH-1:0]     instret,
   output logic                     illegal
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] instret_q;
   logic [6:0]           opcode, funct7;
   logic [2:0]           funct3;
   logic                 is_addi, is_add, is_sub, is_lw, is_sw, is_br, is_jal, legal, taken;
   logic                 alu_sub;
   logic                 unused_bits;
   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};
   assign is_addi     = opcode == 7'b0010011 && funct3 == 3'b000;
   assign is_add      = opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000;
   assign is_sub      = opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0100000;
   assign is_lw       = opcode == 7'b0000011 && funct3 == 3'b010;
   assign is_sw       = opcode == 7'b0100011 && funct3 == 3'b010;
   assign is_br       = opcode == 7'b1100011 && funct3[2:1] == 2'b00;
   assign is_jal      = opcode == 7'b1101111;
   assign legal       = |{is_addi, is_add, is_sub, is_lw, is_sw, is_br, is_jal};
   // BEQ (funct3[0]=0) is taken on EQ, BNE on !EQ
   assign taken       = EQ ^ funct3[0];
   assign ALUctrl     = ALUCTRL_WIDTH'(alu_sub);
   assign instret     = instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_q + CNT_WIDTH'(retire);
      end
   end

   always_comb begin
      state_d   = state_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 2'd0;
      RegWrite  = 1'b0;
      alu_sub   = 1'b0;
      ALUsrc    = 1'b0;
      ImmSrc    = 2'd0;
      ResultSrc = 2'd0;
      retire    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            IRWrite  = imem_ready;
            state_d  = imem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
`ifdef MCU_ILLEGAL_TRAP_EN
            state_d = legal ? S_EXEC : S_TRAP;
`else
            PCWrite = ~legal;
            retire  = ~legal;
            state_d = legal ? S_EXEC : S_FETCH;
`endif
         end
         S_EXEC: begin
            alu_sub = is_sub | is_br;
            ALUsrc  = is_addi | is_lw | is_sw;
            ImmSrc  = is_sw ? 2'd1 : is_br ? 2'd2 : 2'd0;
            PCWrite = is_br;
            retire  = is_br;
            PCsrc   = {1'b0, is_br & taken};
            state_d = is_br ? S_FETCH : (is_lw | is_sw) ? S_MEM : S_WB;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            PCWrite  = is_sw & dmem_ready;
            retire   = is_sw & dmem_ready;
            state_d  = !dmem_ready ? S_MEM : is_sw ? S_FETCH : S_WB;
         end
         S_WB: begin
            RegWrite  = 1'b1;
            PCWrite   = 1'b1;
            retire    = 1'b1;
            ResultSrc = is_lw ? 2'd1 : is_jal ? 2'd2 : 2'd0;
            PCsrc     = is_jal ? 2'd2 : 2'd0;
            ImmSrc    = is_jal ? 2'd3 : 2'd0;
            state_d   = S_FETCH;
         end
         default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
            illegal = 1'b1;
`else
            state_d = S_FETCH;
`endif
         end
      endcase
      // reset masks every output combinationally, including imem_req
      if (!rst_n)
         {imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCsrc, RegWrite, alu_sub, ALUsrc, ImmSrc, ResultSrc, retire, illegal} = '0;
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven and randomized checks of the multicycle control FSM
// against per-instruction expectations (latency, handshakes, enables, selects, retire count).
module tb_multicycle_control_unit;
   localparam logic [31:0] ADDI = 32'h00500093, ADD = 32'h002081B3, SUB = 32'h402081B3,
                           LW = 32'h0080A283, SW = 32'h0050A423, BEQ = 32'h00208063,
                           BNE = 32'h00209063, JAL = 32'h000000EF, ILL = 32'h0000007F;

   typedef struct packed {
      logic [31:0] ins;
      int          iw;
      int          dw;
      logic        eq;
      int          lat;
      logic        rw;
      logic [1:0]  rsrc;
      logic [1:0]  pcsrc;
      logic        mem;
      logic        we;
      logic        alusrc;
      logic        aluc;
      logic [1:0]  imm;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic [31:0] instr = '0;
   logic        EQ = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, IRWrite, PCWrite, RegWrite, ALUsrc, retire, illegal;
   logic [1:0]  PCsrc, ImmSrc, ResultSrc;
   logic [2:0]  ALUctrl;
   logic [31:0] instret;
   logic        o4_imem_req, o4_dmem_req, o4_dmem_we, o4_IRWrite, o4_PCWrite, o4_RegWrite, o4_ALUsrc, o4_retire, o4_illegal;
   logic [1:0]  o4_PCsrc, o4_ImmSrc, o4_ResultSrc;
   logic [2:0]  o4_ALUctrl;
   logic [3:0]  instret4;
   int          passed = 0, total = 0;
   logic [31:0] icount = '0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
      .ResultSrc(ResultSrc), .retire(retire), .instret(instret), .illegal(illegal)
   );

   multicycle_control_unit #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(o4_imem_req), .dmem_req(o4_dmem_req), .dmem_we(o4_dmem_we), .IRWrite(o4_IRWrite),
      .PCWrite(o4_PCWrite), .PCsrc(o4_PCsrc), .RegWrite(o4_RegWrite), .ALUctrl(o4_ALUctrl), .ALUsrc(o4_ALUsrc),
      .ImmSrc(o4_ImmSrc), .ResultSrc(o4_ResultSrc), .retire(o4_retire), .instret(instret4), .illegal(o4_illegal)
   );

   function automatic logic [17:0] outs();
      return {imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, ResultSrc, retire, illegal};
   endfunction

   function automatic logic [17:0] outs4();
      return {o4_imem_req, o4_dmem_req, o4_dmem_we, o4_IRWrite, o4_PCWrite, o4_PCsrc, o4_RegWrite, o4_ALUctrl,
              o4_ALUsrc, o4_ImmSrc, o4_ResultSrc, o4_retire, o4_illegal};
   endfunction

   task automatic check(input string nm, input longint got, input longint exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
   endtask

   function automatic vec_t mk(logic [31:0] ins, int iw, int dw, logic eq, int lat, logic rw, logic [1:0] rsrc,
                               logic [1:0] pcsrc, logic mem, logic we, logic alusrc, logic aluc, logic [1:0] imm);
      vec_t v;
      v.ins = ins; v.iw = iw; v.dw = dw; v.eq = eq; v.lat = lat; v.rw = rw; v.rsrc = rsrc; v.pcsrc = pcsrc;
      v.mem = mem; v.we = we; v.alusrc = alusrc; v.aluc = aluc; v.imm = imm;
      return v;
   endfunction

   // instruction-level reference: what one instruction must do, from its class and wait counts
   function automatic vec_t model(logic [31:0] ins, int iw, int dw, logic eq);
      logic [6:0] op, f7;
      logic [2:0] f3;
      vec_t       v;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      v = '0; v.ins = ins; v.iw = iw; v.dw = dw; v.eq = eq; v.lat = 2;
      if (op == 7'b0010011 && f3 == 3'b000) begin
         v.lat = 4; v.rw = 1; v.alusrc = 1;
      end else if (op == 7'b0110011 && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
         v.lat = 4; v.rw = 1; v.aluc = f7[5];
      end else if (op == 7'b0000011 && f3 == 3'b010) begin
         v.lat = 5 + dw; v.rw = 1; v.rsrc = 1; v.mem = 1; v.alusrc = 1;
      end else if (op == 7'b0100011 && f3 == 3'b010) begin
         v.lat = 4 + dw; v.mem = 1; v.we = 1; v.alusrc = 1; v.imm = 1;
      end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
         v.lat = 3; v.aluc = 1; v.imm = 2; v.pcsrc = ((f3 == 3'b000) == eq) ? 2'd1 : 2'd0;
      end else if (op == 7'b1101111) begin
         v.lat = 4; v.rw = 1; v.rsrc = 2; v.pcsrc = 2;
      end
      v.lat += iw;
      return v;
   endfunction

   task automatic run(input vec_t v);
      int         cyc = 0, ireq = 0, dreq = 0, wec = 0, irw = 0, rwc = 0, pcw = 0;
      logic [1:0] rpc = 0, rsrc = 0, rimm = 0;
      logic       ill = 0, done = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         if (cyc == 0) begin
            instr = v.ins;
            EQ    = v.eq;
         end
         imem_ready = imem_req ? (ireq == v.iw) : 1'($urandom);
         dmem_ready = dmem_req ? (dreq == v.dw) : 1'($urandom);
         #1;
         cyc++;
         if (cyc == 1) begin
            check("instret", instret, icount);
            check("instret4", instret4, icount[3:0]);
         end
         if (imem_req) ireq++;
         if (dmem_req) dreq++;
         if (dmem_we) wec++;
         if (IRWrite) irw++;
         if (RegWrite) rwc++;
         if (PCWrite) pcw++;
         ill |= illegal;
         if (v.lat > 2 && cyc == v.iw + 3) begin
            check("exec_alusrc", ALUsrc, v.alusrc);
            check("exec_aluctrl", ALUctrl, v.aluc);
            check("exec_immsrc", ImmSrc, v.imm);
         end
         if (retire) begin
            done = 1; rpc = PCsrc; rsrc = ResultSrc; rimm = ImmSrc;
         end
      end
      if (done) icount++;
      check("latency", cyc, v.lat);
      check("imem_req_cycles", ireq, v.iw + 1);
      check("irwrite_count", irw, 1);
      check("dmem_req_cycles", dreq, v.mem ? v.dw + 1 : 0);
      check("dmem_we_cycles", wec, v.we ? v.dw + 1 : 0);
      check("regwrite_count", rwc, v.rw);
      check("pcwrite_count", pcw, 1);
      check("pcsrc", rpc, v.pcsrc);
      check("illegal_low", ill, 0);
      if (v.rw) check("resultsrc", rsrc, v.rsrc);
      if (v.pcsrc == 2) check("jal_immsrc", rimm, 3);
   endtask

   task automatic do_reset();
      rst_n = 0; imem_ready = 1; dmem_ready = 1;
      #1;
      check("rst_outs", outs(), 0);
      check("rst_outs4", outs4(), 0);
      check("rst_instret", instret, 0);
      check("rst_instret4", instret4, 0);
      repeat (2) @(posedge clk);
      #1; imem_ready = 0; dmem_ready = 0; rst_n = 1;
      #1;
      check("first_imem_req", imem_req, 1);
      icount = 0;
   endtask

   initial begin
      vec_t        tbl[13];
      logic [31:0] pool[8] = '{ADDI, ADD, SUB, LW, SW, BEQ, BNE, JAL};
      logic [31:0] w;
      int          n, rets;
      tbl[0]  = mk(ADDI, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0);
      tbl[1]  = mk(BNE,  0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 2);
      tbl[2]  = mk(BNE,  0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 2);
      tbl[3]  = mk(BEQ,  0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 1, 2);
      tbl[4]  = mk(BEQ,  0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 2);
      tbl[5]  = mk(LW,   0, 3, 0, 8, 1, 1, 0, 1, 0, 1, 0, 0);
      tbl[6]  = mk(SW,   0, 0, 0, 4, 0, 0, 0, 1, 1, 1, 0, 1);
      tbl[7]  = mk(JAL,  0, 0, 0, 4, 1, 2, 2, 0, 0, 0, 0, 0);
      tbl[8]  = mk(ADD,  2, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[9]  = mk(SUB,  1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0);
      tbl[10] = mk(LW,   0, 0, 1, 5, 1, 1, 0, 1, 0, 1, 0, 0);
      tbl[11] = mk(SW,   1, 2, 0, 7, 0, 0, 0, 1, 1, 1, 0, 1);
      tbl[12] = mk(BNE,  2, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 2);
      #2;
      do_reset();
      for (int i = 0; i < 13; i++) run(tbl[i]);
      for (int k = 0; k < 120; k++) begin
         w = pool[$urandom_range(0, 7)] ^ ($urandom & 32'h01FF_8F80);
`ifndef MCU_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 3) == 0) w = $urandom;
`endif
         run(model(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom)));
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         if (n == 0) instr = LW;
         imem_ready = imem_req;
         dmem_ready = 0;
         #1;
         n++;
      end while (!dmem_req && n < 20);
      check("mem_reached", dmem_req, 1);
      check("mem_cycle", n, 4);
      do_reset();
      for (int i = 0; i < 16; i++) run(model(BEQ, 0, 0, 0));
      @(posedge clk); #2;
      check("wrap_instret4", instret4, 0);
      check("count16_instret", instret, 16);
`ifdef MCU_ILLEGAL_TRAP_EN
      rets = 0;
      @(posedge clk); #1;
      instr = ILL; imem_ready = 1; dmem_ready = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         rets += int'(retire);
         @(posedge clk); #1;
      end
      #1;
      check("trap_illegal", illegal, 1);
      check("trap_other_outs", outs() >> 1, 0);
      check("trap_retires", rets, 0);
      check("trap_instret", instret, icount);
      do_reset();
      check("trap_exit_illegal", illegal, 0);
`else
      rets = 0;
      run(mk(ILL, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      run(mk(ILL, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #2;
      check("nop_instret", instret, icount);
      check("nop_retires", rets, 0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
